// File: rtl/priority_encoder8to3_pkg.sv
// Shared constants, FSM encoding and helpers for the sequential 8:3 priority encoder.
// Optional round-robin arbitration is enabled by defining ROUND_ROBIN_EN.
package priority_encoder8to3_pkg;

    localparam int N_IN  = 8;
    localparam int IDX_W = 3;

    typedef enum logic {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } state_e;

    function automatic logic [N_IN-1:0] idx_onehot(input logic [IDX_W-1:0] idx);
        logic [N_IN-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/pe8_winner.sv
// Combinational winner search over an 8-bit mask: fixed highest-index priority,
// or a wrapping upward search from ptr when ROUND_ROBIN_EN is defined.
module pe8_winner
    import priority_encoder8to3_pkg::*;
(
    input  logic [N_IN-1:0]  mask,
`ifdef ROUND_ROBIN_EN
    input  logic [IDX_W-1:0] ptr,
`endif
    output logic [IDX_W-1:0] idx,
    output logic             any
);

`ifdef ROUND_ROBIN_EN
    logic [IDX_W-1:0] probe;
    logic             found;

    always_comb begin
        idx   = '0;
        any   = |mask;
        probe = '0;
        found = 1'b0;
        for (int k = 0; k < N_IN; k++) begin
            // Index arithmetic wraps naturally at IDX_W bits.
            probe = ptr + IDX_W'(k);
            if (!found && mask[probe]) begin
                idx   = probe;
                found = 1'b1;
            end
        end
    end
`else
    always_comb begin
        idx = '0;
        any = |mask;
        // Ascending scan so the highest set index is the last one written.
        for (int i = 0; i < N_IN; i++) begin
            if (mask[i]) begin
                idx = IDX_W'(i);
            end
        end
    end
`endif

endmodule

// File: rtl/priority_encoder8to3.sv
// Sequential 8:3 priority encoder: sticky pending capture, valid/ready code output.
// Define ROUND_ROBIN_EN to replace fixed priority with a rotating search pointer.
module priority_encoder8to3
    import priority_encoder8to3_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic [N_IN-1:0]  D,
    input  logic             ready,
    output logic [IDX_W-1:0] a,
    output logic             valid,
    output logic [N_IN-1:0]  pending,
    output logic             ovf
);

    // Handshake: a code transfers on a cycle where valid && ready at the rising
    // edge; a is held stable while valid && !ready; ready with valid low is ignored.

    state_e           state_q, state_d;
    logic [IDX_W-1:0] a_q, a_d;
    logic [N_IN-1:0]  pending_q, pending_d;
    logic             ovf_q, ovf_d;

    logic             accept;
    logic [N_IN-1:0]  capture;
    logic [N_IN-1:0]  clr_mask;
    logic [N_IN-1:0]  remaining;
    logic [IDX_W-1:0] win_idx;
    logic             win_any;

`ifdef ROUND_ROBIN_EN
    logic [IDX_W-1:0] ptr_q, ptr_d;
`endif

    assign accept = (state_q == PRESENT) && ready;

    always_comb begin
        capture   = D & {N_IN{enable}};
        clr_mask  = accept ? idx_onehot(a_q) : '0;
        remaining = pending_q & ~clr_mask;
        // Set wins over clear: a re-arriving bit survives its own accept.
        pending_d = remaining | capture;
        ovf_d     = ovf_q | (|(capture & remaining));
    end

`ifdef ROUND_ROBIN_EN
    always_comb begin
        ptr_d = ptr_q;
        if (accept) begin
            ptr_d = a_q + IDX_W'(1);
        end
    end
`endif

    // One search serves both the IDLE load and the back-to-back reload, since
    // remaining equals pending_q whenever nothing is being accepted.
    pe8_winner u_winner (
        .mask (remaining),
`ifdef ROUND_ROBIN_EN
        .ptr  (ptr_d),
`endif
        .idx  (win_idx),
        .any  (win_any)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        case (state_q)
            IDLE: begin
                if (win_any) begin
                    a_d     = win_idx;
                    state_d = PRESENT;
                end
            end
            PRESENT: begin
                if (ready) begin
                    if (win_any) begin
                        a_d = win_idx;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            a_q       <= '0;
            pending_q <= '0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            pending_q <= pending_d;
            ovf_q     <= ovf_d;
        end
    end

`ifdef ROUND_ROBIN_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`endif

    assign a       = a_q;
    assign valid   = (state_q == PRESENT);
    assign pending = pending_q;
    assign ovf     = ovf_q;

endmodule

// File: tb/tb_priority_encoder8to3.sv
// Self-checking bench for priority_encoder8to3; covers ROUND_ROBIN_EN when defined.
module tb_priority_encoder8to3;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic [7:0] D;
    logic       ready;
    logic [2:0] a;
    logic       valid;
    logic [7:0] pending;
    logic       ovf;

    int         checks = 0;
    int         errors = 0;
    logic [2:0] exp_q[$];
    logic [2:0] exp_a;

    always #5 clk = ~clk;

    priority_encoder8to3 dut (
        .clk     (clk),
        .rst     (rst),
        .enable  (enable),
        .D       (D),
        .ready   (ready),
        .a       (a),
        .valid   (valid),
        .pending (pending),
        .ovf     (ovf)
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst    = 1'b1;
        enable = 1'b0;
        ready  = 1'b0;
        D      = 8'h00;
        step;
        step;
        rst = 1'b0;
        exp_q.delete();
    endtask

    task automatic test_reset;
        do_reset;
        checks++;
        if (a !== 3'd0 || valid !== 1'b0 || pending !== 8'h00 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: a=%0d valid=%b pending=%h ovf=%b, required 0 0 00 0", a, valid, pending, ovf);
        end
        enable = 1'b1;
        D      = 8'hA5;
        step;
        D = 8'h00;
        step;
`ifdef ROUND_ROBIN_EN
        exp_a = 3'd0;
`else
        exp_a = 3'd7;
`endif
        checks++;
        if (valid !== 1'b1 || a !== exp_a || pending !== 8'hA5) begin
            errors++;
            $display("FAIL present_a5: valid=%b a=%0d pending=%h, required 1 %0d a5", valid, a, pending, exp_a);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (a !== 3'd0 || valid !== 1'b0 || pending !== 8'h00 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: a=%0d valid=%b pending=%h ovf=%b, required 0 0 00 0", a, valid, pending, ovf);
        end
        step;
        rst = 1'b0;
    endtask

    task automatic test_single_pulse;
        do_reset;
        enable = 1'b1;
        ready  = 1'b1;
        D      = 8'b0000_0100;
        step;
        checks++;
        if (valid !== 1'b0 || pending !== 8'h04) begin
            errors++;
            $display("FAIL pulse_capture: valid=%b pending=%h, required 0 04", valid, pending);
        end
        D = 8'h00;
        exp_q.push_back(3'd2);
        step;
        checks++;
        if (valid !== 1'b1 || exp_q.size() == 0) begin
            errors++;
            $display("FAIL pulse_valid: valid=%b, required 1", valid);
        end else begin
            exp_a = exp_q.pop_front();
            checks++;
            if (a !== exp_a) begin
                errors++;
                $display("FAIL pulse_code: a=%0d, required %0d", a, exp_a);
            end
        end
        step;
        checks++;
        if (valid !== 1'b0 || pending !== 8'h00) begin
            errors++;
            $display("FAIL pulse_drain: valid=%b pending=%h, required 0 00", valid, pending);
        end
    endtask

    task automatic test_multi_hot;
        do_reset;
        enable = 1'b1;
        ready  = 1'b1;
        D      = 8'b1001_0010;
        step;
        D = 8'h00;
        exp_q.push_back(3'd7);
        exp_q.push_back(3'd4);
        exp_q.push_back(3'd1);
        step;
        for (int i = 0; i < 3; i++) begin
            exp_a = exp_q.pop_front();
            checks++;
            if (valid !== 1'b1 || a !== exp_a) begin
                errors++;
                $display("FAIL multi_hot_%0d: valid=%b a=%0d, required 1 %0d", i, valid, a, exp_a);
            end
            step;
        end
        checks++;
        if (valid !== 1'b0 || pending !== 8'h00) begin
            errors++;
            $display("FAIL multi_hot_end: valid=%b pending=%h, required 0 00", valid, pending);
        end
    endtask

    task automatic test_backpressure;
        do_reset;
        enable = 1'b1;
        D      = 8'h01;
        step;
        D = 8'h80;
        step;
        D = 8'h00;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (valid !== 1'b1 || a !== 3'd0) begin
                errors++;
                $display("FAIL backpressure_hold_%0d: valid=%b a=%0d, required 1 0", i, valid, a);
            end
            step;
        end
        exp_q.push_back(3'd0);
        exp_q.push_back(3'd7);
        ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            exp_a = exp_q.pop_front();
            checks++;
            if (valid !== 1'b1 || a !== exp_a) begin
                errors++;
                $display("FAIL backpressure_release_%0d: valid=%b a=%0d, required 1 %0d", i, valid, a, exp_a);
            end
            step;
        end
        checks++;
        if (valid !== 1'b0) begin
            errors++;
            $display("FAIL backpressure_end: valid=%b, required 0", valid);
        end
    endtask

    task automatic test_overflow;
        do_reset;
        enable = 1'b1;
        D      = 8'h08;
        step;
        checks++;
        if (ovf !== 1'b0) begin
            errors++;
            $display("FAIL ovf_first_hit: ovf=%b, required 0", ovf);
        end
        step;
        D = 8'h00;
        checks++;
        if (ovf !== 1'b1 || valid !== 1'b1 || a !== 3'd3) begin
            errors++;
            $display("FAIL ovf_second_hit: ovf=%b valid=%b a=%0d, required 1 1 3", ovf, valid, a);
        end
        step;
        step;
        checks++;
        if (ovf !== 1'b1) begin
            errors++;
            $display("FAIL ovf_sticky: ovf=%b, required 1", ovf);
        end
    endtask

    task automatic test_set_wins;
        do_reset;
        enable = 1'b1;
        D      = 8'h08;
        step;
        D = 8'h00;
        step;
        ready = 1'b1;
        D     = 8'h08;
        step;
        D = 8'h00;
        checks++;
        if (pending !== 8'h08 || valid !== 1'b0 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL set_wins_pending: pending=%h valid=%b ovf=%b, required 08 0 0", pending, valid, ovf);
        end
        step;
        checks++;
        if (valid !== 1'b1 || a !== 3'd3) begin
            errors++;
            $display("FAIL set_wins_regrant: valid=%b a=%0d, required 1 3", valid, a);
        end
        step;
        checks++;
        if (valid !== 1'b0 || pending !== 8'h00) begin
            errors++;
            $display("FAIL set_wins_drain: valid=%b pending=%h, required 0 00", valid, pending);
        end
    endtask

    task automatic test_enable_gate;
        do_reset;
        enable = 1'b0;
        D      = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            step;
        end
        checks++;
        if (pending !== 8'h00 || valid !== 1'b0 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL enable_gate: pending=%h valid=%b ovf=%b, required 00 0 0", pending, valid, ovf);
        end
        D = 8'h00;
    endtask

    task automatic test_back_to_back;
        logic [7:0] mask;
        do_reset;
        enable = 1'b1;
        ready  = 1'b1;
        for (int it = 0; it < 6; it++) begin
            mask = 8'($urandom_range(1, 255));
            D    = mask;
            step;
            D = 8'h00;
            for (int b = 7; b >= 0; b--) begin
                if (mask[b]) exp_q.push_back(3'(b));
            end
            for (int c = 0; c < 12; c++) begin
                step;
                if (valid === 1'b1) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL b2b_extra_grant: mask=%h a=%0d, required no grant", mask, a);
                    end else begin
                        exp_a = exp_q.pop_front();
                        if (a !== exp_a) begin
                            errors++;
                            $display("FAIL b2b_code: mask=%h a=%0d, required %0d", mask, a, exp_a);
                        end
                    end
                end
            end
            checks++;
            if (exp_q.size() != 0 || valid !== 1'b0) begin
                errors++;
                $display("FAIL b2b_missing: mask=%h left=%0d valid=%b, required 0 0", mask, exp_q.size(), valid);
                exp_q.delete();
            end
        end
    endtask

`ifdef ROUND_ROBIN_EN
    task automatic test_round_robin;
        do_reset;
        enable = 1'b1;
        ready  = 1'b1;
        D      = 8'hFF;
        step;
        step;
        for (int i = 0; i < 9; i++) exp_q.push_back(3'(i % 8));
        for (int i = 0; i < 9; i++) begin
            exp_a = exp_q.pop_front();
            checks++;
            if (valid !== 1'b1 || a !== exp_a) begin
                errors++;
                $display("FAIL rr_rotation_%0d: valid=%b a=%0d, required 1 %0d", i, valid, a, exp_a);
            end
            step;
        end
        ready  = 1'b0;
        enable = 1'b0;
        step;
        for (int i = 0; i < 3; i++) step;
        checks++;
        if (pending !== 8'hFF) begin
            errors++;
            $display("FAIL rr_enable_off: pending=%h, required ff", pending);
        end
    endtask
`endif

    initial begin
        test_reset;
        test_single_pulse;
        test_backpressure;
        test_overflow;
        test_set_wins;
        test_enable_gate;
`ifdef ROUND_ROBIN_EN
        test_round_robin;
`else
        test_multi_hot;
        test_back_to_back;
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/priority_encoder8to3.md
Name: priority_encoder8to3

Overview:
Sequential 8:3 priority encoder; the inverse of the team's 3:8 decoder. It captures event lines D[7:0] into a sticky pending register and presents the encoded index of the winning line on a[2:0] with a valid/ready handshake. It clears each pending bit once its code is accepted. It sits in front of any consumer that needs a compact event or interrupt index.

Parameters:
N_IN, 8, number of event lines; fixed at 8 for this revision.
IDX_W, 3, code width, log2(N_IN).

Ports:
clk  input  1  clock, rising edge.
rst  input  1  reset, asynchronous, active-high.
enable  input  1  capture enable for D.
D  input  8  event lines; sampled each cycle; level or pulse.
ready  input  1  consumer accepts a this cycle.
a  output  3  encoded index of the granted line.
valid  output  1  a is meaningful.
pending  output  8  sticky pending register (status/debug).
ovf  output  1  sticky: an event hit a bit that was already pending.

Behaviour:
- Reset (async, rst=1): pending=8'h00, a=3'b000, valid=0, ovf=0; round-robin pointer=0 if the optional feature is compiled in. Reset mid-handshake discards the presented code.
- Capture at each edge: pending_next = (pending & ~clr_mask) | (D & {8{enable}}).
  - clr_mask is one-hot of a when valid&&ready; otherwise 0.
  - Set wins over clear on the same bit in the same cycle.
- enable=0: no new captures. Pending bits are retained and drained normally.
- ovf is set when enable && D[i] && pending[i] && !(clearing bit i this cycle), for any i. It is cleared only by rst.
- Two-state FSM:
  - IDLE (valid=0): if pending!=0, load a=winner(pending) and go to PRESENT. Otherwise stay.
  - PRESENT (valid=1): a is held stable while !ready, even if a higher-priority bit arrives.
  - PRESENT on valid&&ready:
    - If (pending & ~clr_mask)!=0, load a=winner(pending & ~clr_mask) and stay in PRESENT. This gives back-to-back grants with one code per cycle.
    - Else go to IDLE with valid=0 next cycle.
- Latency: D[i] high at edge k with pending empty → pending[i]=1 after edge k, valid=1 and a=i after edge k+1 (2 edges).
- Fixed priority (default): the highest set index wins (bit 7 highest, bit 0 lowest).
- Bit accepted on the same cycle it re-arrives: the bit stays pending and is granted again later.
- ready while valid=0: ignored.

Optional Feature:
Macro ROUND_ROBIN_EN.
- Defined: a 3-bit pointer ptr selects priority.
  - The search starts at index ptr and proceeds upward with wrap (ptr, ptr+1 … 7, 0 … ptr-1); the first set bit wins.
  - On each accept of code g, ptr = g+1 mod 8; 7 wraps to 0.
  - ptr is not updated without an accept.
- Undefined: no pointer; fixed priority as above.

Decomposition:
- Shared package: N_IN, IDX_W, FSM state encoding (IDLE=1'b0, PRESENT=1'b1).
- One natural sub-module, pe8_winner: combinational, 8-bit mask in (plus ptr when ROUND_ROBIN_EN) → 3-bit index and any-set flag. It is reused for both the IDLE load and the back-to-back reload.

Test Plan:
- Reset: assert rst mid-PRESENT with pending=8'hA5 → immediately a=0, valid=0, pending=0, ovf=0.
- Single pulse: enable=1, D=8'b0000_0100 for one cycle, ready=1 → valid=1 with a=3'b010 two edges later for exactly one cycle, then pending=0.
- Multi-hot priority (fixed): D=8'b1001_0010 in one cycle, ready=1 → successive codes 7, 4, 1 on consecutive cycles with valid held, then valid=0.
- Backpressure: pending=8'h01, valid, a=0, ready=0 for 5 cycles while D=8'h80 arrives → a stays 0. After ready=1 the next code is 7.
- Overflow and set-wins: D=8'h08 twice while bit 3 is pending and not accepted → ovf=1. Separately, accept code 3 on the same cycle D[3]=1 → pending[3] stays 1 and a=3 is granted again.
- ROUND_ROBIN_EN: pending=8'hFF held by re-asserting D=8'hFF, ready=1 → codes 0,1,2,…,7,0 in rotation. Also enable=0 with D=8'hFF → no capture, pending unchanged.
